// File: rtl/uart_flit_rx.sv
// uart_flit_rx: 8N1 UART receiver with 16x oversampling and 2-of-3 voting.
// It packs received bytes, most-significant byte first, into DATA_WIDTH flits
// and presents each flit on a valid/ready interface.
module uart_flit_rx #(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTES_PER_FLIT = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_BITS   = 32
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  Rs232_Rx,
  input  logic [2:0]            baud_set,
  output logic [7:0]            rx_byte,
  output logic                  byte_valid,
  output logic [DATA_WIDTH-1:0] flit_data,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  timeout,
  output logic                  rx_busy
);

  localparam int unsigned DIV_9600   = CLK_FREQ / (9600 * 16) - 1;
  localparam int unsigned DIV_19200  = CLK_FREQ / (19200 * 16) - 1;
  localparam int unsigned DIV_38400  = CLK_FREQ / (38400 * 16) - 1;
  localparam int unsigned DIV_57600  = CLK_FREQ / (57600 * 16) - 1;
  localparam int unsigned DIV_115200 = CLK_FREQ / (115200 * 16) - 1;
  localparam int unsigned DIV_W      = (DIV_9600 > 0) ? $clog2(DIV_9600 + 1) : 1;
  localparam int unsigned BC_W       = $clog2(BYTES_PER_FLIT);
  localparam int unsigned IC_W       = $clog2(TIMEOUT_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic             sync1, sync2, edge_q;
  logic [1:0]       settle_cnt;
  logic             armed;
  logic [DIV_W-1:0] div_sel, div_lat, div_cnt;
  logic             tick;
  state_t           state, state_next;
  logic [3:0]       samp_cnt;
  logic [2:0]       bit_cnt;
  logic             vote6, vote7, maj;
  logic [7:0]       data_sr;
  logic             mid_sample, bit_end;
  logic             start_det, stop_ok, stop_bad;
  logic [BC_W-1:0]  byte_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic             word_done;
  logic [IC_W-1:0]  idle_cnt;
  logic             timeout_hit;

  // Line synchroniser, edge flop, and arming so a line held low out of reset is not a start
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      edge_q     <= 1'b1;
      settle_cnt <= 2'd0;
      armed      <= 1'b0;
    end else begin
      sync1  <= Rs232_Rx;
      sync2  <= sync1;
      edge_q <= sync2;
      if (!settle_cnt[1]) settle_cnt <= settle_cnt + 1'b1;
      if (settle_cnt[1] && sync2) armed <= 1'b1;
    end
  end

  // Baud select to oversampling divider
  always_comb begin
    div_sel = DIV_W'(DIV_9600);
    case (baud_set)
      3'd1:    div_sel = DIV_W'(DIV_19200);
      3'd2:    div_sel = DIV_W'(DIV_38400);
      3'd3:    div_sel = DIV_W'(DIV_57600);
      3'd4:    div_sel = DIV_W'(DIV_115200);
      default: div_sel = DIV_W'(DIV_9600);
    endcase
  end

  assign tick        = (div_cnt >= div_lat);
  assign mid_sample  = tick && (samp_cnt == 4'd8);
  assign bit_end     = tick && (samp_cnt == 4'd15);
  assign maj         = (vote6 & vote7) | (vote6 & sync2) | (vote7 & sync2);
  assign timeout_hit = (state == S_IDLE) && !start_det && (byte_cnt != '0) && bit_end &&
                       (idle_cnt == IC_W'(TIMEOUT_BITS - 1));

  // Tick divider; baud latched only between frames, phase restarted on each start bit
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div_lat <= DIV_W'(DIV_9600);
      div_cnt <= '0;
    end else begin
      if (state == S_IDLE) div_lat <= div_sel;
      if (start_det || tick) div_cnt <= '0;
      else                   div_cnt <= div_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_next;
  end

  // FSM next state and frame strobes; stop bit ends the frame at its mid sample
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        if (armed && edge_q && !sync2) begin
          start_det  = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        if (mid_sample && maj) state_next = S_IDLE;
        else if (bit_end)      state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_cnt == 3'd7)) state_next = S_STOP;
      end
      S_STOP: begin
        if (mid_sample) begin
          state_next = S_IDLE;
          stop_ok    = maj;
          stop_bad   = !maj;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Sample/bit counters, vote capture and LSB-first data shift; byte and error strobes
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      samp_cnt   <= 4'd0;
      bit_cnt    <= 3'd0;
      vote6      <= 1'b1;
      vote7      <= 1'b1;
      data_sr    <= 8'd0;
      rx_byte    <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      if (start_det || ((state != S_IDLE) && (state_next == S_IDLE))) samp_cnt <= 4'd0;
      else if (tick)                                                   samp_cnt <= samp_cnt + 1'b1;
      if (tick && (samp_cnt == 4'd6)) vote6 <= sync2;
      if (tick && (samp_cnt == 4'd7)) vote7 <= sync2;
      if (start_det)                          bit_cnt <= 3'd0;
      else if ((state == S_DATA) && bit_end)  bit_cnt <= bit_cnt + 1'b1;
      if ((state == S_DATA) && mid_sample) data_sr <= {maj, data_sr[7:1]};
      if (stop_ok) rx_byte <= data_sr;
      byte_valid <= stop_ok;
      frame_err  <= stop_bad;
      rx_busy    <= (state_next != S_IDLE);
    end
  end

  // Flit assembler: shift bytes in MSB-first, flag a completed word
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      byte_cnt  <= '0;
      shift_reg <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (stop_bad || timeout_hit) begin
        byte_cnt <= '0;
      end else if (byte_valid) begin
        shift_reg <= {shift_reg[DATA_WIDTH-9:0], rx_byte};
        if (byte_cnt == BC_W'(BYTES_PER_FLIT - 1)) begin
          byte_cnt  <= '0;
          word_done <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

  // Output register: load when empty or draining this cycle, otherwise drop and flag
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      flit_data  <= '0;
      flit_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done) begin
        if (!flit_valid || flit_ready) begin
          flit_data  <= shift_reg;
          flit_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (flit_valid && flit_ready) begin
        flit_valid <= 1'b0;
      end
    end
  end

  // Idle bit-time counter that discards a stale partial flit
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= timeout_hit;
      if (start_det || (byte_cnt == '0) || timeout_hit) idle_cnt <= '0;
      else if ((state == S_IDLE) && bit_end)            idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_flit_rx.sv
// tb_uart_flit_rx: scoreboard bench for uart_flit_rx (32-bit and 64-bit instances).
module tb_uart_flit_rx;

  localparam int unsigned CLK_FREQ = 3_686_400;
  localparam int BIT32 = 32;   // clk cycles per bit at baud_set=4
  localparam int BIT64 = 384;  // clk cycles per bit at baud_set=0

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic rx32 = 1'b1, rx64 = 1'b1;
  logic ready32 = 1'b1, ready64 = 1'b0;
  logic [2:0] baud32 = 3'd4, baud64 = 3'd0;

  logic [7:0]  rx_byte32, rx_byte64;
  logic        byte_valid32, byte_valid64;
  logic [31:0] flit_data32;
  logic [63:0] flit_data64;
  logic        flit_valid32, flit_valid64;
  logic        frame_err32, frame_err64, overrun32, overrun64;
  logic        timeout32, timeout64, rx_busy32, rx_busy64;

  int checks = 0, errors = 0;
  int cyc = 0, bytes_seen = 0, fe_cnt = 0, ov_cnt = 0, to_cnt = 0;
  int bv_cyc = 0, to_cyc = 0, last_bv = 0;

  logic [7:0]  q_byte[$];
  logic [31:0] q_flit[$];
  logic [63:0] q_flit64[$];
  logic [7:0]  eb;
  logic [31:0] ef;
  logic [63:0] ef64;

  uart_flit_rx #(.CLK_FREQ(CLK_FREQ), .DATA_WIDTH(32)) dut32 (
    .clk(clk), .nreset(nreset), .Rs232_Rx(rx32), .baud_set(baud32),
    .rx_byte(rx_byte32), .byte_valid(byte_valid32), .flit_data(flit_data32),
    .flit_valid(flit_valid32), .flit_ready(ready32), .frame_err(frame_err32),
    .overrun(overrun32), .timeout(timeout32), .rx_busy(rx_busy32));

  uart_flit_rx #(.CLK_FREQ(CLK_FREQ), .DATA_WIDTH(64)) dut64 (
    .clk(clk), .nreset(nreset), .Rs232_Rx(rx64), .baud_set(baud64),
    .rx_byte(rx_byte64), .byte_valid(byte_valid64), .flit_data(flit_data64),
    .flit_valid(flit_valid64), .flit_ready(ready64), .frame_err(frame_err64),
    .overrun(overrun64), .timeout(timeout64), .rx_busy(rx_busy64));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitors: byte strobes, flit handshakes and flag pulses
  always @(negedge clk) begin
    if (nreset) begin
      if (byte_valid32) begin
        bytes_seen++;
        bv_cyc = cyc;
        if (q_byte.size() == 0) check("byte_unexpected", 64'(q_byte.size()), 64'd1);
        else begin
          eb = q_byte.pop_front();
          check("rx_byte", 64'(rx_byte32), 64'(eb));
        end
      end
      if (flit_valid32 && ready32) begin
        if (q_flit.size() == 0) check("flit_unexpected", 64'(q_flit.size()), 64'd1);
        else begin
          ef = q_flit.pop_front();
          check("flit_data", 64'(flit_data32), 64'(ef));
        end
      end
      if (flit_valid64 && ready64) begin
        if (q_flit64.size() == 0) check("flit64_unexpected", 64'(q_flit64.size()), 64'd1);
        else begin
          ef64 = q_flit64.pop_front();
          check("flit64_data", flit_data64, ef64);
        end
      end
      if (frame_err32) fe_cnt++;
      if (overrun32)   ov_cnt++;
      if (timeout32) begin
        to_cnt++;
        to_cyc = cyc;
      end
    end
  end

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx64 = v;
    else     rx32 = v;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop);
    int bc;
    bc = sel ? BIT64 : BIT32;
    if (!sel && stop) q_byte.push_back(b);
    set_line(sel, 1'b0);
    repeat (bc) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, b[i]);
      repeat (bc) @(posedge clk);
    end
    set_line(sel, stop);
    repeat (bc) @(posedge clk);
    set_line(sel, 1'b1);
  endtask

  task automatic send_word32(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(1'b0, w[8*i +: 8], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT32) @(posedge clk);
  endtask

  task automatic accept_one32();
    @(posedge clk); #1 ready32 = 1'b1;
    @(posedge clk); #1 ready32 = 1'b0;
  endtask

  // Raise flit_ready exactly on the cycle the assembled word is offered to the output register
  task automatic pulse_on_word(input int target);
    int n, guard;
    n = 0;
    guard = 0;
    while (n < target && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (byte_valid32) n++;
    end
    check("pulse_wait", 64'(n), 64'(target));
    @(posedge clk); #1 ready32 = 1'b1;
    @(posedge clk); #1 ready32 = 1'b0;
  endtask

  initial begin
    int d, n0, fe0;
    logic [63:0] w64;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rx_byte", 64'(rx_byte32), 64'd0);
    check("rst_flit_data", 64'(flit_data32), 64'd0);
    check("rst_flit_valid", 64'(flit_valid32), 64'd0);
    check("rst_rx_busy", 64'(rx_busy32), 64'd0);
    nreset = 1'b1;
    idle_bits(2);

    // Basic 4-byte flit with ready held high
    q_flit.push_back(32'h12345678);
    send_word32(32'h12345678);
    idle_bits(2);
    check("t1_flit_drained", 64'(q_flit.size()), 64'd0);
    check("t1_frame_err", 64'(fe_cnt), 64'd0);
    check("t1_overrun", 64'(ov_cnt), 64'd0);
    check("t1_timeout", 64'(to_cnt), 64'd0);
    check("t1_flit_valid", 64'(flit_valid32), 64'd0);

    // 64-bit flit at 9600 baud, held until ready
    w64 = 64'h0102030405060708;
    q_flit64.push_back(w64);
    for (int i = 7; i >= 0; i--) send_byte(1'b1, w64[8*i +: 8], 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t2_valid_held", 64'(flit_valid64), 64'd1);
    check("t2_data_held", flit_data64, w64);
    @(posedge clk); #1 ready64 = 1'b1;
    @(posedge clk); #1 ready64 = 1'b0;
    @(negedge clk);
    check("t2_valid_drop", 64'(flit_valid64), 64'd0);
    check("t2_q_empty", 64'(q_flit64.size()), 64'd0);

    // Overrun: second flit dropped while first is unconsumed
    @(posedge clk); #1 ready32 = 1'b0;
    q_flit.push_back(32'hA1A2A3A4);
    send_word32(32'hA1A2A3A4);
    send_word32(32'hB1B2B3B4);
    idle_bits(2);
    check("t3_overrun", 64'(ov_cnt), 64'd1);
    check("t3_data_kept", 64'(flit_data32), 64'hA1A2A3A4);
    check("t3_valid_kept", 64'(flit_valid32), 64'd1);
    accept_one32();
    @(negedge clk);
    check("t3_valid_clear", 64'(flit_valid32), 64'd0);

    // Simultaneous drain and load: no overrun, new flit replaces old
    q_flit.push_back(32'hC1C2C3C4);
    q_flit.push_back(32'hD1D2D3D4);
    send_word32(32'hC1C2C3C4);
    idle_bits(1);
    check("t3b_c_loaded", 64'(flit_data32), 64'hC1C2C3C4);
    fork
      send_word32(32'hD1D2D3D4);
      pulse_on_word(4);
    join
    idle_bits(1);
    check("t3b_overrun", 64'(ov_cnt), 64'd1);
    check("t3b_d_loaded", 64'(flit_data32), 64'hD1D2D3D4);
    check("t3b_valid", 64'(flit_valid32), 64'd1);
    accept_one32();
    @(posedge clk); #1 ready32 = 1'b1;

    // Frame error discards the byte and any partial flit
    send_byte(1'b0, 8'h99, 1'b1);
    send_byte(1'b0, 8'hA5, 1'b0);
    idle_bits(1);
    check("t4_frame_err", 64'(fe_cnt), 64'd1);
    q_flit.push_back(32'h11223344);
    send_word32(32'h11223344);
    idle_bits(2);
    check("t4_fe_once", 64'(fe_cnt), 64'd1);
    check("t4_flit", 64'(flit_data32), 64'h11223344);

    // Timeout of a partial flit after 32 idle bit-times
    send_byte(1'b0, 8'hAA, 1'b1);
    send_byte(1'b0, 8'hBB, 1'b1);
    last_bv = bv_cyc;
    idle_bits(40);
    check("t5_timeout", 64'(to_cnt), 64'd1);
    d = to_cyc - last_bv;
    check("t5_timeout_delay", 64'(d >= 1008 && d <= 1040), 64'd1);
    q_flit.push_back(32'h01020304);
    send_word32(32'h01020304);
    idle_bits(2);
    check("t5_flit", 64'(flit_data32), 64'h01020304);
    check("t5_timeout_once", 64'(to_cnt), 64'd1);

    // Short low glitch is a false start
    n0 = bytes_seen;
    fe0 = fe_cnt;
    rx32 = 1'b0;
    repeat (8) @(posedge clk);
    rx32 = 1'b1;
    idle_bits(3);
    check("glitch_no_byte", 64'(bytes_seen), 64'(n0));
    check("glitch_no_fe", 64'(fe_cnt), 64'(fe0));
    check("glitch_idle", 64'(rx_busy32), 64'd0);

    // Reset mid-byte with the line low through reset release
    send_byte(1'b0, 8'h55, 1'b1);
    send_byte(1'b0, 8'h66, 1'b1);
    rx32 = 1'b0;
    repeat (BIT32) @(posedge clk);
    rx32 = 1'b1; repeat (BIT32) @(posedge clk);
    rx32 = 1'b0; repeat (BIT32) @(posedge clk);
    @(negedge clk);
    check("t6_busy_before", 64'(rx_busy32), 64'd1);
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rx_byte", 64'(rx_byte32), 64'd0);
    check("t6_byte_valid", 64'(byte_valid32), 64'd0);
    check("t6_flit_data", 64'(flit_data32), 64'd0);
    check("t6_flit_valid", 64'(flit_valid32), 64'd0);
    check("t6_flags", 64'({frame_err32, overrun32, timeout32}), 64'd0);
    check("t6_rx_busy", 64'(rx_busy32), 64'd0);
    nreset = 1'b1;
    n0 = bytes_seen;
    fe0 = fe_cnt;
    idle_bits(20);
    rx32 = 1'b1;
    idle_bits(2);
    check("t6_low_no_byte", 64'(bytes_seen), 64'(n0));
    check("t6_low_no_fe", 64'(fe_cnt), 64'(fe0));
    q_flit.push_back(32'hC0FFEE11);
    send_word32(32'hC0FFEE11);
    idle_bits(2);
    check("t6_flit", 64'(flit_data32), 64'hC0FFEE11);

    check("end_byte_q", 64'(q_byte.size()), 64'd0);
    check("end_flit_q", 64'(q_flit.size()), 64'd0);
    check("end_flit64_q", 64'(q_flit64.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_flit_rx.md
Name: uart_flit_rx

Overview:
- UART receive path for the router test platform: the counterpart of the on-board byte transmitter.
- Recovers 8N1 bytes from the RS232 RX pin using 16x oversampling and majority voting.
- Packs BYTES_PER_FLIT consecutive bytes, most-significant byte first, into one DATA_WIDTH flit.
- Presents the flit on a valid/ready handshake so a host PC can inject flits into the router without push-button stimulus.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- DATA_WIDTH, 32, flit width. Must be a multiple of 8; legal values are 32 and 64.
- BYTES_PER_FLIT, DATA_WIDTH/8, number of bytes per flit. Derived; do not override.
- TIMEOUT_BITS, 32, idle bit-times after which a partly assembled flit is discarded.

Ports:
- clk  input  1  system clock
- nreset  input  1  asynchronous active-low reset
- Rs232_Rx  input  1  asynchronous serial input; idles high
- baud_set  input  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=9600
- rx_byte  output  8  last correctly framed byte
- byte_valid  output  1  one-cycle pulse when rx_byte updates
- flit_data  output  DATA_WIDTH  assembled flit
- flit_valid  output  1  flit_data holds an unconsumed flit
- flit_ready  input  1  consumer accepts the flit when flit_valid=1
- frame_err  output  1  one-cycle pulse on a bad stop bit
- overrun  output  1  one-cycle pulse when a completed flit is dropped
- timeout  output  1  one-cycle pulse when a partial flit is discarded
- rx_busy  output  1  high from start-bit detection until the end of the stop-bit sample

Behaviour:
- Reset and synchronisation
  - Clock is clk. Reset is nreset, asynchronous, active-low.
  - During reset every output is 0, including flit_data and rx_byte. The synchroniser flops reset to 1.
  - Rs232_Rx passes through a 2-flop synchroniser plus one edge flop. A start condition is a synchronised 1->0 transition while in IDLE.
- Oversampling tick generator
  - Tick divider = CLK_FREQ/(baud*16) - 1, using integer division.
  - The divider is evaluated from baud_set. baud_set is sampled only in IDLE, so a change mid-frame takes effect on the next frame.
  - One tick is one clk pulse. The sample counter runs 0..15 per bit.
  - Ticks 6, 7 and 8 are sampled; a 2-of-3 majority gives the bit value.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
  - START: a majority of 1 means a false start; return to IDLE with no flag.
  - DATA: 8 bits, LSB first. Bit counter 0..7.
  - STOP, majority 1: rx_byte loads and byte_valid pulses on the cycle after the tick-8 sample.
  - STOP, majority 0: frame_err pulses, the byte is discarded, and the assembly byte count clears to 0.
  - After the stop sample the FSM returns to IDLE immediately without waiting for tick 15. This allows back-to-back frames with clock skew up to about 3/16 bit.
- Assembler
  - On byte_valid: shift_reg <= {shift_reg[DATA_WIDTH-9:0], rx_byte}, and byte_cnt increments.
  - On reaching BYTES_PER_FLIT, byte_cnt wraps to 0 and the word is complete.
  - Example: bytes B0..B3 produce flit_data = {B0,B1,B2,B3}.
- Output register
  - A completed word loads flit_data and sets flit_valid the following cycle, but only if flit_valid=0 or the same cycle holds flit_valid&flit_ready.
  - Otherwise the new word is dropped, overrun pulses, and flit_data and flit_valid are unchanged.
  - flit_valid clears on flit_valid&flit_ready, unless a simultaneous load occurs, in which case it stays 1 with the new data.
  - flit_data is stable while flit_valid=1 and flit_ready=0.
- Timeout
  - When byte_cnt != 0 and the FSM is in IDLE, an idle counter counts bit-times (16 ticks each).
  - At TIMEOUT_BITS bit-times: byte_cnt clears to 0 and timeout pulses.
  - The idle counter clears on any start detection.
  - When byte_cnt = 0, timeout never fires.
- Reset mid-frame: the FSM returns to IDLE and all partial state is lost. A line held low at reset release is not treated as a start until it has returned high.

Test Plan:
- baud_set=4, CLK_FREQ=50e6 (divider 26), send 0x12, 0x34, 0x56, 0x78 with flit_ready=1 -> four byte_valid pulses with rx_byte 0x12, 0x34, 0x56, 0x78, then one flit_valid cycle with flit_data=0x12345678; no error flags.
- DATA_WIDTH=64, baud_set=0, send 0x01..0x08 back-to-back with flit_ready=0 -> flit_data=0x0102030405060708 and flit_valid held; raise flit_ready -> flit_valid drops the next cycle.
- flit_ready=0, send 8 bytes (DATA_WIDTH=32) -> first flit retained; the second completion pulses overrun once and flit_data is still 0x… of the first flit. Repeat with flit_ready pulsed on the completion cycle -> no overrun, new flit loaded.
- Send 0xA5 with stop bit forced 0, then 0x11, 0x22, 0x33, 0x44 -> frame_err pulses once, no byte_valid for 0xA5, flit_data=0x11223344.
- Send 0xAA, 0xBB, then idle 40 bit-times, then 0x01..0x04 -> timeout pulses once about 32 bit-times after the 0xBB stop bit, flit_data=0x01020304. Separately, a 4-tick low glitch on Rs232_Rx produces no byte_valid.
- Assert nreset mid-byte during the DATA state -> all outputs 0, rx_busy=0; the next full 4-byte sequence assembles correctly.
